// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - F3_* : funct3 encodings of the eight M-extension operations
//   - state_t : control FSM states of muldiv_unit
//   - is_div() : true for the division/remainder group (funct3[2] set)
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the unsigned multiply/divide
// datapath. {hi, lo} is the 2*XLEN working register.
//   Multiply (is_div = 0): lo holds the remaining multiplier bits, hi the
//     partial product. If lo[0] is set, opd is added into hi; the whole
//     {carry, hi, lo} is then shifted right by one.
//   Divide (is_div = 1): lo holds the remaining dividend bits (and collects
//     quotient bits from the right), hi the partial remainder. {hi, lo} is
//     shifted left by one and opd is subtracted from the new remainder when
//     it fits (restoring division).
// Ports:
//   is_div   in   1     select divide step instead of multiply step
//   hi, lo   in   XLEN  working register halves before the step
//   opd      in   XLEN  multiplicand or divisor (absolute value)
//   hi_next  out  XLEN  upper half after the step
//   lo_next  out  XLEN  lower half after the step
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opd,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            fits;

  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    rem_sh = {hi, lo[XLEN-1]};
    fits   = (rem_sh >= {1'b0, opd});
    // When the divisor fits, the difference is below the divisor, so the
    // dropped top bit of rem_sh is always cancelled by the subtraction.
    diff   = rem_sh[XLEN-1:0] - opd;

    if (is_div) begin
      hi_next = fits ? diff : rem_sh[XLEN-1:0];
      lo_next = {lo[XLEN-2:0], fits};
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Operates on absolute values with UNROLL shift-add / shift-subtract steps
// per cycle, then applies the sign fix-up on the edge that enters FIN.
// Division by zero and signed overflow are resolved at acceptance and go
// straight to FIN.
// Ports:
//   clk       in   1     rising-edge clock
//   rst_n     in   1     synchronous active-low reset (also clears result_o)
//   start_i   in   1     request, sampled only while busy_o = 0
//   funct3_i  in   3     operation select (MUL..REMU)
//   op_a_i    in   XLEN  rs1 value, sampled with start_i
//   op_b_i    in   XLEN  rs2 value, sampled with start_i
//   flush_i   in   1     abort; wins over a simultaneous start_i
//   busy_o    out  1     operation in progress
//   done_o    out  1     one-cycle completion pulse
//   result_o  out  XLEN  result, held until the next done_o
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned N        = XLEN / UNROLL;
  localparam int unsigned CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       f3_q;
  logic             sa_q, sb_q;
  logic [XLEN-1:0]  hi_q, lo_q, opd_q;
  logic [XLEN-1:0]  result_q;

  // ---------------------------------------------------------------------
  // Acceptance: operand signs, absolute values and special cases
  // ---------------------------------------------------------------------
  logic            accept;
  logic            signed_a, signed_b;
  logic            sign_a, sign_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] abs_a, abs_b, special_result;

  assign accept = (state_q == IDLE) && start_i && !flush_i;

  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (funct3_i)
      F3_MULH, F3_DIV, F3_REM: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      F3_MULHSU: signed_a = 1'b1;
      F3_MUL, F3_MULHU, F3_DIVU, F3_REMU: begin
        signed_a = 1'b0;
        signed_b = 1'b0;
      end
      default: begin
        signed_a = 1'b0;
        signed_b = 1'b0;
      end
    endcase

    sign_a = signed_a & op_a_i[XLEN-1];
    sign_b = signed_b & op_b_i[XLEN-1];
    // The most-negative value maps onto itself, which is its correct
    // unsigned magnitude.
    abs_a  = sign_a ? ('0 - op_a_i) : op_a_i;
    abs_b  = sign_b ? ('0 - op_b_i) : op_b_i;

    div_zero = is_div(funct3_i) && (op_b_i == '0);
    div_ovf  = is_div(funct3_i) && !funct3_i[0] &&
               (op_a_i == MOST_NEG) && (op_b_i == '1);
    special  = div_zero || div_ovf;

    // funct3[1] separates the remainder ops from the quotient ops.
    special_result = '0;
    if (div_zero) begin
      special_result = funct3_i[1] ? op_a_i : '1;
    end else if (div_ovf) begin
      special_result = funct3_i[1] ? '0 : op_a_i;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath: UNROLL chained steps per cycle
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] hi_step, lo_step;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    logic [XLEN-1:0] hi_in, lo_in, hi_out, lo_out;

    if (i == 0) begin : g_first
      assign hi_in = hi_q;
      assign lo_in = lo_q;
    end else begin : g_next
      assign hi_in = g_step[i-1].hi_out;
      assign lo_in = g_step[i-1].lo_out;
    end

    muldiv_step #(
      .XLEN(XLEN)
    ) u_step (
      .is_div (is_div(f3_q)),
      .hi     (hi_in),
      .lo     (lo_in),
      .opd    (opd_q),
      .hi_next(hi_out),
      .lo_next(lo_out)
    );
  end

  assign hi_step = g_step[UNROLL-1].hi_out;
  assign lo_step = g_step[UNROLL-1].lo_out;

  // ---------------------------------------------------------------------
  // Sign fix-up of the final step output. Applied on the edge entering
  // FIN so result_o is already registered in the done_o cycle.
  // ---------------------------------------------------------------------
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_result;

  always_comb begin
    prod     = {hi_step, lo_step};
    prod_fix = (sa_q ^ sb_q) ? ('0 - prod) : prod;
    quo_fix  = (sa_q ^ sb_q) ? ('0 - lo_step) : lo_step;
    rem_fix  = sa_q ? ('0 - hi_step) : hi_step;

    if (is_div(f3_q)) begin
      final_result = f3_q[1] ? rem_fix : quo_fix;
    end else begin
      final_result = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0]
                                      : prod_fix[2*XLEN-1:XLEN];
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    busy_o  = (state_q != IDLE);
    done_o  = (state_q == FIN);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = special ? FIN : CALC;
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opd_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= ((state_q == CALC) && (state_d == CALC)) ? cnt_q + CNT_W'(1) : '0;

      if (accept) begin
        f3_q  <= funct3_i;
        sa_q  <= sign_a;
        sb_q  <= sign_b;
        hi_q  <= '0;
        lo_q  <= abs_a;
        opd_q <= abs_b;
        if (special) begin
          result_q <= special_result;
        end
      end else if ((state_q == CALC) && !flush_i) begin
        hi_q <= hi_step;
        lo_q <= lo_step;
        if (cnt_q == CNT_LAST) begin
          result_q <= final_result;
        end
      end
    end
  end

  assign result_o = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit for the execute stage of the rv32im_zbb core, alongside the single-cycle ALU. The `funct3` field of an OP instruction with `funct7 = 0000001` selects one of the eight M-extension operations. The unit computes the result over a fixed number of cycles and signals completion through a start/busy/done handshake that the pipeline uses to stall. It is parametrised in data width and in bits retired per cycle.

## Interface
- `XLEN`, 32: operand and result width; must be even.
- `UNROLL`, 1: bits processed per iteration; legal values are 1, 2, 4, and it must divide `XLEN`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start_i`  in  1  request; sampled only while `busy_o` = 0.
- `funct3_i`  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a_i`  in  XLEN  rs1 value; sampled with `start_i`.
- `op_b_i`  in  XLEN  rs2 value; sampled with `start_i`.
- `flush_i`  in  1  abort the current operation (pipeline flush).
- `busy_o`  out  1  operation in progress.
- `done_o`  out  1  one-cycle pulse; `result_o` is valid in this cycle.
- `result_o`  out  XLEN  result; held until the next `done_o`.

## Operation
- **FSM states:** IDLE, CALC, FIN.
  - IDLE→CALC on an accepted `start_i`.
  - IDLE→FIN directly for division special cases.
  - CALC→FIN when the iteration counter reaches N−1, where N = `XLEN`/`UNROLL`.
  - FIN→IDLE unconditionally.
- **Operand latch:** at acceptance the unit latches `funct3`, records the sign of each operand that is treated as signed, and stores absolute values. Signed operands are a and b for MULH, DIV, REM; a only for MULHSU.
- **Multiply:** unsigned shift-add on the 2·`XLEN` product, `UNROLL` multiplier bits per cycle.
  - In FIN the full product is negated if the result sign is negative, with sign = sa ^ sb.
  - MUL returns the low `XLEN` bits; the MULH variants return the high `XLEN` bits.
- **Divide:** restoring division, `UNROLL` quotient bits per cycle.
  - In FIN the quotient is negated if sa ^ sb; the remainder is negated if sa.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- **Special cases** (detected at acceptance, skip CALC):
  - Divide by zero: quotient = all ones; remainder = `op_a_i`.
  - Signed overflow (DIV/REM, a = most-negative, b = −1): quotient = a; remainder = 0.
- **Abort:**
  - `flush_i` forces IDLE at the next edge with no `done_o`, and `result_o` keeps its old value.
  - If `flush_i` and `start_i` are high in the same cycle, flush wins and the start is dropped.
  - Deasserting `rst_n` mid-operation behaves like a flush and also clears `result_o`.
- **Ignored inputs:** `start_i` while `busy_o` = 1 is ignored, and operands are not re-sampled.

## Timing
- **Reset values:** state IDLE, `busy_o` = 0, `done_o` = 0, `result_o` = 0, counter 0.
- **Normal operation** (start accepted in cycle 0):
  - `busy_o` = 1 in cycles 1..N+1.
  - `done_o` = 1 in cycle N+1 only.
  - `busy_o` = 0 in cycle N+2, when a new start can be accepted.
  - Default parameters: done in cycle 33.
- **Special cases:** `busy_o` = 1 and `done_o` = 1 in cycle 1; the unit is ready again in cycle 2.
- **Result update:** `result_o` is registered and changes only at the edge that enters FIN. It is stable from the `done_o` cycle onward.
- **Throughput:** one operation per N+2 cycles. There is no back-to-back acceptance in the FIN cycle.

## Structure
- **Package `muldiv_pkg`:** funct3 localparams (`F3_MUL` … `F3_REMU`), the state enum (IDLE/CALC/FIN), and an `is_div(funct3)` helper (funct3[2]).
- **Sub-module `muldiv_step`:** a combinational one-bit shift-add / shift-subtract step. `muldiv_unit` instantiates it `UNROLL` times in a generate loop, chained within one cycle.
- **Top level:** the FSM, counter, sign fix-up and special-case logic stay in `muldiv_unit`.

## Test plan
- **MUL / MULH:** MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB with `done_o` in cycle 33. MULH 0x80000000 × 0x80000000 → 0x40000000.
- **MULHSU / MULHU:** MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- **Signed division:** DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM 0xFFFFFFF9 % 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14.
- **Special cases:** each sets `done_o` in cycle 1.
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 % 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- **Flush and busy rules:**
  - Flush in cycle 10 of a DIV: no `done_o`, `busy_o` = 0 in cycle 11, `result_o` unchanged.
  - A new MUL started in cycle 11 completes in cycle 44.
  - `start_i` while busy is ignored.
  - Asserting `rst_n` = 0 mid-MUL clears `result_o`.
- **Parameter sweep:** with `UNROLL` = 2, DIVU 0xFFFFFFFF / 3 → 0x55555555 with `done_o` in cycle 17. With `XLEN` = 16, MUL 0x00FF × 0x0101 → 0xFFFF.
